writeback_unit: RTL

Write-side front end for the RISC-V register file. Accepts results from a single-cycle ALU path and a long-latency memory/multi-cycle path, buffers memory results in a small FIFO, and serializes everything onto the register file's single write port (reg_write, write_reg, write_data). It preserves program order per destination register, discards writes to x0, and reports pending writes so decode can stall on read-after-write hazards.

---
 rtl/writeback_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/writeback_unit.sv
// writeback_unit
//   Write-side front end for the register file. Results arrive from a
//   single-cycle ALU path and a long-latency memory path; memory results are
//   buffered in a small FIFO, and everything is serialized onto the register
//   file's single write port. Writes to x0 are accepted and dropped.
//   An ALU result is held off while an older memory result to the same
//   register is still queued, so per-register program order is preserved.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   alu_valid/alu_ready         ALU result handshake (ready is combinational)
//   alu_rd, alu_data            ALU destination and result
//   mem_valid/mem_ready         memory result handshake (ready is combinational)
//   mem_rd, mem_data            memory destination and result
//   query_rs1/2, rs1/2_pending  hazard query: a write to that register is
//                               still queued or on the write port
//   reg_write, write_reg,       registered register file write port
//   write_data
module writeback_unit #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic [4:0]  query_rs1,
  input  logic [4:0]  query_rs2,
  output logic        rs1_pending,
  output logic        rs2_pending,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [AW:0]   count_reg, count_next;

  logic          reg_write_reg, reg_write_next;
  logic [4:0]    write_reg_reg, write_reg_next;
  logic [31:0]   write_data_reg, write_data_next;

  logic [DEPTH-1:0] entry_valid, alu_hit, rs1_hit, rs2_hit;
  logic alu_conflict, alu_accept, mem_accept, push, pop, fifo_full;

  // An entry is live when its distance from the read pointer (modulo DEPTH)
  // is below the occupancy count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [AW-1:0] offset;
      assign offset          = AW'(gi) - rd_ptr_reg;
      assign entry_valid[gi] = {1'b0, offset} < count_reg;
      assign alu_hit[gi]     = entry_valid[gi] && (rd_mem[gi] == alu_rd);
      assign rs1_hit[gi]     = entry_valid[gi] && (rd_mem[gi] == query_rs1);
      assign rs2_hit[gi]     = entry_valid[gi] && (rd_mem[gi] == query_rs2);
    end
  endgenerate

  assign fifo_full    = (count_reg == FULL_COUNT);
  assign alu_conflict = (alu_rd != 5'd0) && (|alu_hit);
  assign mem_ready    = !fifo_full;
  assign alu_ready    = !fifo_full && !alu_conflict;
  assign alu_accept   = alu_valid && alu_ready;
  assign mem_accept   = mem_valid && mem_ready;
  // x0 results are consumed by the handshake but never stored.
  assign push         = mem_accept && (mem_rd != 5'd0);

  assign rs1_pending = (query_rs1 != 5'd0) &&
                       ((|rs1_hit) || (reg_write_reg && (write_reg_reg == query_rs1)));
  assign rs2_pending = (query_rs2 != 5'd0) &&
                       ((|rs2_hit) || (reg_write_reg && (write_reg_reg == query_rs2)));

  // Write-port arbitration: a non-x0 ALU result wins; otherwise the FIFO head
  // drains. A full FIFO or a conflict blocks the ALU, so the head always moves.
  always_comb begin
    pop             = 1'b0;
    reg_write_next  = 1'b0;
    write_reg_next  = write_reg_reg;
    write_data_next = write_data_reg;
    if (alu_accept && (alu_rd != 5'd0)) begin
      reg_write_next  = 1'b1;
      write_reg_next  = alu_rd;
      write_data_next = alu_data;
    end else if (count_reg != '0) begin
      pop             = 1'b1;
      reg_write_next  = 1'b1;
      write_reg_next  = rd_mem[rd_ptr_reg];
      write_data_next = data_mem[rd_ptr_reg];
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Entry storage needs no reset: occupancy alone decides which entries count.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_reg]   <= mem_rd;
      data_mem[wr_ptr_reg] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      reg_write_reg  <= 1'b0;
      write_reg_reg  <= 5'd0;
      write_data_reg <= 32'd0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg      <= count_next;
      reg_write_reg  <= reg_write_next;
      write_reg_reg  <= write_reg_next;
      write_data_reg <= write_data_next;
    end
  end

  assign reg_write  = reg_write_reg;
  assign write_reg  = write_reg_reg;
  assign write_data = write_data_reg;

endmodule
